// File: rtl/div_clk_pkg.sv
// Shared state encodings and limits for the programmable clock divider.
// Optional tick output is enabled by defining DIV_CLK_TICK_EN.
package div_clk_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PEND  = 2'd2,
    ST_DRAIN = 2'd3
  } div_st_e;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/div_clk_odd_fix.sv
// Negedge retime of the posedge phase flop and even/odd output select.
// Odd ratios AND the two phases so the high time is exactly N/2 clk periods.
module div_clk_odd_fix (
  input  logic clk,
  input  logic rst_n,
  input  logic pos_q,
  input  logic odd,
  output logic clk_out
);

  logic neg_d, neg_q;

  always_comb neg_d = pos_q;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) neg_q <= 1'b0;
    else        neg_q <= neg_d;
  end

  // Both mux inputs are flop outputs; clk itself never reaches clk_out.
  always_comb clk_out = odd ? (pos_q & neg_q) : pos_q;

endmodule

// File: rtl/div_clk_prog.sv
// Runtime-programmable 50%-duty clock divider with glitch-free reload and start/stop.
// Define DIV_CLK_TICK_EN to add the tick clock-enable output.
module div_clk_prog
  import div_clk_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             load_ack,
  output logic             cfg_err,
  output logic             clk_out
`ifdef DIV_CLK_TICK_EN
  ,
  output logic             tick
`endif
);

  localparam logic [CNT_W-1:0] DEF_R = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] MIN_R = CNT_W'(MIN_DIV);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  div_st_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             pos_q, pos_d;
  logic             load_ack_q, load_ack_d;
  logic             cfg_err_q, cfg_err_d;

  logic             bad_val, wrap, run;
  logic [CNT_W-1:0] ld_val, hi_len;

  always_comb begin
    bad_val = div_load && (div_val < MIN_R);
    ld_val  = (div_val < MIN_R) ? MIN_R : div_val;
    wrap    = (cnt_q == (div_cur_q - ONE));
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    load_ack_d = 1'b0;
    cfg_err_d  = cfg_err_q | bad_val;
    run        = 1'b0;

    if (state_q == ST_STOP) begin
      cnt_d  = '0;
      pend_d = 1'b0;
      // A reload that arrived on the stopping boundary lands here; a fresh load wins.
      if (div_load) begin
        div_cur_d  = ld_val;
        load_ack_d = 1'b1;
      end else if (pend_q) begin
        div_cur_d  = pend_val_q;
        load_ack_d = 1'b1;
      end
      if (en) begin
        state_d = ST_RUN;
        run     = 1'b1;
      end
    end else begin
      if (wrap) begin
        cnt_d = '0;
        if (pend_q) begin
          div_cur_d  = pend_val_q;
          load_ack_d = 1'b1;
          pend_d     = 1'b0;
        end
        run = en;
      end else begin
        cnt_d = cnt_q + ONE;
        run   = 1'b1;
      end
      // Loads seen on a boundary queue for the following boundary (last wins).
      if (div_load) begin
        pend_d     = 1'b1;
        pend_val_d = ld_val;
      end
      if (!run)        state_d = ST_STOP;
      else if (!en)    state_d = ST_DRAIN;
      else if (pend_d) state_d = ST_PEND;
      else             state_d = ST_RUN;
    end

    // High phase is ceil(N/2) posedge cycles; the odd fixup trims half a cycle.
    hi_len = div_cur_d - (div_cur_d >> 1);
    pos_d  = run && (cnt_d < hi_len);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_STOP;
      cnt_q      <= '0;
      div_cur_q  <= DEF_R;
      pend_q     <= 1'b0;
      pend_val_q <= DEF_R;
      pos_q      <= 1'b0;
      load_ack_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      pos_q      <= pos_d;
      load_ack_q <= load_ack_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign load_ack = load_ack_q;
  assign cfg_err  = cfg_err_q;

  div_clk_odd_fix u_odd_fix (
    .clk     (clk),
    .rst_n   (rst_n),
    .pos_q   (pos_q),
    .odd     (div_cur_q[0]),
    .clk_out (clk_out)
  );

`ifdef DIV_CLK_TICK_EN
  logic tick_d, tick_q;

  // First cycle of every running period; pos_d is already low whenever stopped.
  always_comb tick_d = pos_d && (cnt_d == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_q <= 1'b0;
    else        tick_q <= tick_d;
  end

  assign tick = tick_q;
`endif

endmodule
